// File: rtl/dlatch_seq_driver_if.sv
// Host-side bus between the latch self-test sequencer and its surroundings.
interface dlatch_seq_driver_if;
    logic       start;
    logic [1:0] lat_in;
    logic [1:0] lat_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [2:0] fail_step;

    // Sequencer side: drives the latch and reports results
    modport master (
        input  start,
        input  lat_out,
        output lat_in,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_step
    );

    // Host/latch side: starts runs, returns the latch output
    modport slave (
        output start,
        output lat_out,
        input  lat_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_step
    );
endinterface

// File: rtl/dlatch_seq_driver.sv
// Self-test sequencer for the NOR D-latch cell: seven-step write/hold pattern,
// synchronised read-back, error count and first failing step.
module dlatch_seq_driver #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    dlatch_seq_driver_if.master bus
);

    localparam int unsigned CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned STEP_W    = 3;
    localparam int unsigned LAST_STEP = 6;
    localparam int unsigned NO_FAIL   = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_lat_in;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [2:0]          r_err_count;
    logic [2:0]          r_fail_step;
    logic [1:0]          r_sync [SYNC_STAGES];

    logic [1:0]          w_sync;
    logic                w_exp_q;
    logic                w_mismatch;
    logic                w_sample;
    logic                w_err_hit;
    logic [2:0]          w_err_next;
    logic                w_upset;

    // {data, enable} applied to the latch for each step
    function automatic logic [1:0] step_pattern(input logic [STEP_W-1:0] step);
        case (step)
            3'd1, 3'd5: step_pattern = 2'b01;
            3'd3:       step_pattern = 2'b11;
            3'd4:       step_pattern = 2'b10;
            default:    step_pattern = 2'b00;
        endcase
    endfunction

    // Q the latch must hold at the end of each step
    function automatic logic step_exp_q(input logic [STEP_W-1:0] step);
        step_exp_q = (step == 3'd3) || (step == 3'd4);
    endfunction

    // Latch output is asynchronous: bring it into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 2'b00;
            end
        end else begin
            r_sync[0] <= bus.lat_out;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Sample-point compare; Q==notQ falls out as a mismatch for either expQ
    always_comb begin
        w_sync     = r_sync[SYNC_STAGES-1];
        w_exp_q    = step_exp_q(r_step);
        w_mismatch = (w_sync[0] != w_exp_q) || (w_sync[1] != ~w_exp_q);
        w_sample   = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
        w_err_hit  = w_sample && (r_step != 3'd0) && w_mismatch;
        w_err_next = r_err_count + 3'(w_err_hit);
        w_upset    = (r_step > STEP_W'(LAST_STEP)) || (r_cnt > CNT_W'(HOLD_CYCLES - 1));
    end

    // Run sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_cnt       <= '0;
            r_lat_in    <= 2'b00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_fail_step <= 3'(NO_FAIL);
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_lat_in <= 2'b00;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    if (bus.start) begin
                        r_state     <= S_DRIVE;
                        r_step      <= '0;
                        r_cnt       <= '0;
                        r_lat_in    <= step_pattern(3'd0);
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_count <= 3'd0;
                        r_fail_step <= 3'(NO_FAIL);
                    end
                end
                S_DRIVE: begin
                    if (w_upset) begin
                        r_state  <= S_IDLE;
                        r_lat_in <= 2'b00;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b0;
                    end else if (w_sample) begin
                        r_err_count <= w_err_next;
                        if (w_err_hit && (r_fail_step == 3'(NO_FAIL))) begin
                            r_fail_step <= r_step;
                        end
                        r_cnt <= '0;
                        if (r_step == STEP_W'(LAST_STEP)) begin
                            r_state  <= S_DONE;
                            r_lat_in <= 2'b00;
                            r_done   <= 1'b1;
                            r_pass   <= (w_err_next == 3'd0);
                        end else begin
                            r_step   <= r_step + 3'd1;
                            r_lat_in <= step_pattern(r_step + 3'd1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_lat_in <= 2'b00;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_lat_in <= 2'b00;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lat_in    = r_lat_in;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.fail_step = r_fail_step;

endmodule

// File: tb/tb_dlatch_seq_driver.sv
// Bench for dlatch_seq_driver: latch cell stand-in with fault modes, a
// run-timeline model checked every cycle, and directed literal checks.
module tb_dlatch_seq_driver;

    localparam int H  = 20;
    localparam int SS = 2;
    localparam int RUN_END = 7 * H;

    logic clk;
    logic rst_n;
    int   mode;        // 0 ideal, 1 Q stuck 0, 2 swapped, 3 both high
    logic r_q;
    int   n_cmp;
    int   n_err;

    dlatch_seq_driver_if bus ();

    dlatch_seq_driver #(
        .HOLD_CYCLES (H),
        .SYNC_STAGES (SS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latch cell stand-in
    always_latch begin
        if (bus.lat_in[0]) r_q <= bus.lat_in[1];
    end

    assign bus.lat_out = (mode == 1) ? 2'b10 :
                         (mode == 2) ? {r_q, ~r_q} :
                         (mode == 3) ? 2'b11 : {~r_q, r_q};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int pat_en [7] = '{0, 1, 0, 1, 0, 1, 0};
    int pat_d  [7] = '{0, 0, 0, 1, 1, 0, 0};
    int exp_q  [7] = '{0, 0, 0, 1, 1, 0, 0};

    function automatic int ideal_q(input int k);
        int q = 0;
        for (int i = 1; i <= k; i++) if (pat_en[i] != 0) q = pat_d[i];
        return q;
    endfunction

    function automatic bit step_fails(input int md, input int k);
        int q  = ideal_q(k);
        int oq;
        int onq;
        case (md)
            1:       begin oq = 0;     onq = 1;     end
            2:       begin oq = 1 - q; onq = q;     end
            3:       begin oq = 1;     onq = 1;     end
            default: begin oq = q;     onq = 1 - q; end
        endcase
        return (oq != exp_q[k]) || (onq != 1 - exp_q[k]);
    endfunction

    bit m_run  = 1'b0;
    int m_t    = 0;
    int m_err  = 0;
    int m_fail = 7;
    int m_pass = 0;
    int tt, te, tf, tk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_t    <= 0;
            m_err  <= 0;
            m_fail <= 7;
            m_pass <= 0;
        end else if (!m_run) begin
            if (bus.start) begin
                m_run  <= 1'b1;
                m_t    <= 0;
                m_err  <= 0;
                m_fail <= 7;
                m_pass <= 0;
            end
        end else begin
            tt = m_t + 1;
            te = m_err;
            tf = m_fail;
            if ((tt % H == 0) && (tt <= RUN_END)) begin
                tk = tt / H - 1;
                if (tk >= 1 && step_fails(mode, tk)) begin
                    te = te + 1;
                    if (tf == 7) tf = tk;
                end
            end
            m_t    <= tt;
            m_err  <= te;
            m_fail <= tf;
            if (tt == RUN_END) m_pass <= (te == 0) ? 1 : 0;
            if (tt == RUN_END + 1) m_run <= 1'b0;
        end
    end

    int n_done;
    // Every-cycle compare against the model
    always @(negedge clk) begin
        int e_lat;
        e_lat = (m_run && m_t < RUN_END) ? (pat_d[m_t / H] * 2 + pat_en[m_t / H]) : 0;
        check("lat_in",    int'(bus.lat_in),    e_lat);
        check("busy",      int'(bus.busy),      int'(m_run));
        check("done",      int'(bus.done),      (m_run && m_t == RUN_END) ? 1 : 0);
        check("pass",      int'(bus.pass),      m_pass);
        check("err_count", int'(bus.err_count), m_err);
        check("fail_step", int'(bus.fail_step), m_fail);
        if (bus.done) n_done++;
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(input int j0, output int j);
        bit ok;
        j  = j0;
        ok = 1'b0;
        while (j < j0 + 400) begin
            @(posedge clk);
            j++;
            #1;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    // Start at posedge+2, finish at posedge+2 after busy has dropped
    task automatic do_run(input int md, input int e_err, input int e_fail,
                          input int e_pass, input string nm);
        int j;
        int d0;
        mode = md;
        d0 = n_done;
        bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        wait_done(0, j);
        check({nm, "_latency"}, j, 140);
        check({nm, "_err"},  int'(bus.err_count), e_err);
        check({nm, "_fail"}, int'(bus.fail_step), e_fail);
        check({nm, "_pass"}, int'(bus.pass),      e_pass);
        @(posedge clk);
        #1 check({nm, "_busy_low"}, int'(bus.busy), 0);
        check({nm, "_done_pulses"}, n_done - d0, 1);
        #1;
    endtask

    initial begin
        int j;
        int d0;
        n_cmp = 0;
        n_err = 0;
        n_done = 0;
        mode = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_lat_in", int'(bus.lat_in),    0);
        check("rst_busy",   int'(bus.busy),      0);
        check("rst_done",   int'(bus.done),      0);
        check("rst_pass",   int'(bus.pass),      0);
        check("rst_err",    int'(bus.err_count), 0);
        check("rst_fail",   int'(bus.fail_step), 7);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        do_run(0, 0, 7, 1, "ideal");
        do_run(1, 2, 3, 0, "stuck0");
        do_run(2, 6, 1, 0, "swapped");
        do_run(3, 6, 1, 0, "both1");
        do_run(0, 0, 7, 1, "ideal2");

        // start re-pulsed mid-run must be ignored
        mode = 0;
        d0 = n_done;
        bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        repeat (50) @(posedge clk);
        #2 bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        wait_done(51, j);
        check("repulse_latency", j, 140);
        @(posedge clk);
        #1 check("repulse_busy_low", int'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1 check("repulse_done_pulses", n_done - d0, 1);
        #1;

        // start held high: back-to-back runs one IDLE cycle apart
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        wait_done(0, j);
        check("held_first", j, 140);
        check("held_first_pass", int'(bus.pass), 1);
        #1;
        wait_done(140, j);
        check("held_second", j, 282);
        check("held_second_pass", int'(bus.pass), 1);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        // async reset in the middle of step 3
        mode = 2;
        bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        repeat (65) @(posedge clk);
        #1 check("pre_rst_lat_in", int'(bus.lat_in),    3);
        check("pre_rst_fail",      int'(bus.fail_step), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_lat_in", int'(bus.lat_in),    0);
        check("mid_rst_busy",   int'(bus.busy),      0);
        check("mid_rst_fail",   int'(bus.fail_step), 7);
        check("mid_rst_err",    int'(bus.err_count), 0);
        repeat (2) @(posedge clk);
        #2;
        mode = 0;
        rst_n = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("post_rst_step1", int'(bus.lat_in), 1);
        wait_done(20, j);
        check("post_rst_latency", j, 140);
        check("post_rst_pass",    int'(bus.pass),      1);
        check("post_rst_fail",    int'(bus.fail_step), 7);
        repeat (3) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dlatch_seq_driver.md
# dlatch_seq_driver

Self-test sequencer for the binary NOR D-latch cell. It drives the latch's 2-bit input (enable, data) through a fixed seven-step write/hold pattern and reads back the latch's 2-bit output (Q, notQ). Each result is compared against a behavioural latch model, and the block reports pass/fail, an error count and the first failing step. It sits on the host side of the latch cell, in place of the simulation stimulus, so the cell can be exercised on silicon from one clock.

## Interface
- HOLD_CYCLES, default 20: clock cycles each step is held; must be >= SYNC_STAGES+2.
- SYNC_STAGES, default 2: flip-flop stages synchronising lat_out (the latch output is asynchronous).
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled; starts a run when the block is idle.
- lat_in  output  2  drives the latch under test; [0]=enable (latch clock), [1]=data; registered.
- lat_out  input  2  output of the latch under test; [0]=Q, [1]=notQ.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  1 when the last completed run had zero errors.
- err_count  output  3  number of failing checked steps in the current or last run.
- fail_step  output  3  index of the first failing step; 7 = none.

## Operation
- Step pattern (enable,data), steps 0..6: (0,0) (1,0) (0,0) (1,1) (0,1) (1,0) (0,0).
- Expected Q after each step: step 0 unchecked (latch state unknown); steps 1..6 expect 0,0,1,1,0,0. Expected notQ = ~expected Q.
- FSM states:
  - IDLE: lat_in=00. When start=1, go to DRIVE with step=0 and hold counter cnt=0; clear err_count, set fail_step=7, clear pass.
  - DRIVE: lat_in=pattern[step]; cnt increments each cycle.
    - When cnt==HOLD_CYCLES-1, compare the synchronised lat_out against the expected values, provided the step is checked (steps 1..6).
    - Mismatch means Q!=expQ or notQ!=~expQ. Q==notQ is always a mismatch.
    - On a mismatch, err_count increments; if fail_step is 7, it takes the step index.
    - Then cnt resets to 0 and step increments. After step 6, go to DONE.
  - DONE: lat_in=00, done=1, pass set to (err_count==0, including a mismatch counted in the final step). Go to IDLE next cycle.
- start is ignored in DRIVE and DONE. A held start re-triggers from IDLE.
- err_count never exceeds 6, so no saturation is needed.
- Results (pass, err_count, fail_step) hold until the next run starts.
- busy is high in DRIVE and DONE.
- State, step and cnt encodings are outside the listed legal values only on an upset; such a state returns to IDLE.

## Timing
- Reset values:
  - lat_in=00, busy=0, done=0, pass=0, err_count=0, fail_step=7.
  - FSM in IDLE; synchroniser flops cleared.
- Reset mid-run aborts immediately (asynchronous): lat_in goes to 00, busy to 0, and the results take their reset values.
- Edge E0 is the edge that samples start=1 in IDLE.
- Step k drives lat_in from edge E0+k·HOLD_CYCLES for exactly HOLD_CYCLES cycles.
- Step k's sample is taken at edge E0+(k+1)·HOLD_CYCLES, using the synchronised value. That value reflects lat_out SYNC_STAGES cycles earlier.
- err_count and fail_step update at the sample edge.
- done is high for one cycle after edge E0+7·HOLD_CYCLES, and pass is valid in that same cycle.
- busy falls at edge E0+7·HOLD_CYCLES+1.
- Total run time is 7·HOLD_CYCLES+1 cycles. The latch propagation plus settle time must be under HOLD_CYCLES-SYNC_STAGES-1 cycles.

## Test plan
- Ideal latch model connected (Q follows data while enable=1, holds otherwise; notQ=~Q); pulse start: lat_in sequence matches the pattern with each step HOLD_CYCLES long; done at E0+140 (defaults); pass=1, err_count=0, fail_step=7.
- Q stuck at 0 with notQ=1: err_count=2 (steps 3,4), fail_step=3, pass=0.
- Q and notQ swapped relative to the model: err_count=6, fail_step=1, pass=0.
- Both outputs forced to 1: err_count=6, fail_step=1; a second run with the ideal model then reports pass=1, err_count=0, fail_step=7.
- start pulsed again during DRIVE: ignored; the run completes in 141 cycles with a single done pulse. start held high continuously: back-to-back runs, each one cycle apart via IDLE.
- rst_n asserted mid-step 3: lat_in=00, busy=0, fail_step=7 within the same cycle. After release with start=1, a complete run starts from step 0.
